// File: rtl/config_loader.sv
// ---------------------------------------------------------------------------
// config_loader
//   Loads the kFPGA core configuration shift register from a word stream.
//   A start pulse clears the register (cfg_nreset low for CLEAR_CYCLES),
//   then each accepted word is serialised LSB first, one bit per clock,
//   until exactly CONFIG_WIDTH bits have been shifted. The fabric reset
//   (core_nreset) is released only once loading has completed.
//
//   Optional feature macro: CONFIG_LOADER_CRC_EN
//     When defined, a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first)
//     runs over every shifted bit. One trailer word is then accepted; a
//     mismatch with trailer[15:0] sets the sticky crc_error flag and keeps
//     the fabric in reset. When undefined, crc_error is tied low.
//
// Ports
//   clock       in   system/config clock, rising edge
//   nreset      in   asynchronous active-low reset
//   start       in   begin a load (honoured in IDLE or DONE)
//   abort       in   cancel a load, return to IDLE
//   word_data   in   bitstream word, LSB shifted first
//   word_valid  in   word_data valid
//   word_ready  out  word accepted this cycle when word_valid is high
//   cfg_bit     out  serial data to config_in
//   cfg_enable  out  shift enable to the config register
//   cfg_nreset  out  active-low clear of the config register
//   core_nreset out  active-low fabric reset
//   busy        out  load in progress
//   done        out  configuration complete
//   crc_error   out  sticky CRC mismatch flag
// ---------------------------------------------------------------------------
module config_loader #(
  parameter int CONFIG_WIDTH = 1602,
  parameter int WORD_WIDTH   = 32,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_bit,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  output logic                  core_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_error
);

  localparam int BCW = $clog2(CONFIG_WIDTH + 1);
  localparam int WIW = $clog2(WORD_WIDTH + 1);
  localparam int CCW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SHIFT, S_CHECK, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CCW-1:0]        clr_cnt_q, clr_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WIW-1:0]        word_idx_q, word_idx_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;

  logic word_ready_q, word_ready_d;
  logic cfg_bit_q, cfg_bit_d;
  logic cfg_enable_q, cfg_enable_d;
  logic cfg_nreset_q, cfg_nreset_d;
  logic core_nreset_q, core_nreset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic crc_error_d;

`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_error_q;
`endif

  // word_ready_q mirrors LOAD/CHECK, so this is the accepted-word strobe.
  logic handshake;
  assign handshake = word_valid && word_ready_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    buf_d       = buf_q;
`ifdef CONFIG_LOADER_CRC_EN
    crc_d       = crc_q;
    crc_error_d = crc_error_q;
`else
    crc_error_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // abort outranks start, even when idle
        if (!abort && start) state_d = S_CLEAR;
      end
      S_DONE: begin
        if (abort)      state_d = S_IDLE;
        else if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (clr_cnt_q == CCW'(CLEAR_CYCLES - 1)) begin
          state_d = S_LOAD;
        end else begin
          clr_cnt_d = clr_cnt_q + CCW'(1);
        end
      end
      S_LOAD: begin
        // abort drops a word offered in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (handshake) begin
          buf_d      = word_data;
          word_idx_d = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          buf_d      = buf_q >> 1;
          bit_cnt_d  = bit_cnt_q + BCW'(1);
          word_idx_d = word_idx_q + WIW'(1);
`ifdef CONFIG_LOADER_CRC_EN
          // buf_q[0] is the bit on cfg_bit this cycle
          crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ buf_q[0]) ? 16'h1021 : 16'h0000);
`endif
          // The config width limit wins over word exhaustion, so the
          // unused upper bits of the final word are never shifted.
          if (bit_cnt_q == BCW'(CONFIG_WIDTH - 1)) begin
`ifdef CONFIG_LOADER_CRC_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else if (word_idx_q == WIW'(WORD_WIDTH - 1)) begin
            state_d = S_LOAD;
          end
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (handshake) begin
`ifdef CONFIG_LOADER_CRC_EN
          crc_error_d = (word_data[15:0] != crc_q);
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering CLEAR resets all per-load bookkeeping.
    if (state_d == S_CLEAR && state_q != S_CLEAR) begin
      clr_cnt_d   = '0;
      bit_cnt_d   = '0;
      buf_d       = '0;
`ifdef CONFIG_LOADER_CRC_EN
      crc_d       = 16'hFFFF;
`endif
      crc_error_d = 1'b0;
    end

    // Outputs are registered images of the next state, so each output
    // lines up with the state it describes.
    word_ready_d  = (state_d == S_LOAD) || (state_d == S_CHECK);
    cfg_enable_d  = (state_d == S_SHIFT);
    cfg_bit_d     = (state_d == S_SHIFT) ? buf_d[0] : 1'b0;
    cfg_nreset_d  = (state_d != S_CLEAR);
    busy_d        = (state_d == S_CLEAR) || (state_d == S_LOAD) ||
                    (state_d == S_SHIFT) || (state_d == S_CHECK);
    done_d        = (state_d == S_DONE);
    core_nreset_d = (state_d == S_DONE) && !crc_error_d;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      buf_q         <= '0;
      word_ready_q  <= 1'b0;
      cfg_bit_q     <= 1'b0;
      cfg_enable_q  <= 1'b0;
      cfg_nreset_q  <= 1'b0;
      core_nreset_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
      crc_q         <= 16'hFFFF;
      crc_error_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      buf_q         <= buf_d;
      word_ready_q  <= word_ready_d;
      cfg_bit_q     <= cfg_bit_d;
      cfg_enable_q  <= cfg_enable_d;
      cfg_nreset_q  <= cfg_nreset_d;
      core_nreset_q <= core_nreset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef CONFIG_LOADER_CRC_EN
      crc_q         <= crc_d;
      crc_error_q   <= crc_error_d;
`endif
    end
  end

  assign word_ready  = word_ready_q;
  assign cfg_bit     = cfg_bit_q;
  assign cfg_enable  = cfg_enable_q;
  assign cfg_nreset  = cfg_nreset_q;
  assign core_nreset = core_nreset_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef CONFIG_LOADER_CRC_EN
  assign crc_error   = crc_error_q;
`else
  assign crc_error   = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// ---------------------------------------------------------------------------
// tb_config_loader
//   Self-checking bench for config_loader with default parameters.
//   A table of load scenarios {pattern, gap, crc_bad, expected enables,
//   expected start-to-done latency, expected handshake spacing} is applied
//   in a loop; hand-written sequences cover abort, start-while-busy and
//   asynchronous reset mid-load. A model of the external shift register is
//   built from cfg_bit/cfg_enable/cfg_nreset and compared against the
//   register image expected from the word stream.
//   Honours CONFIG_LOADER_CRC_EN (trailer word and crc_error checks).
// ---------------------------------------------------------------------------
module tb_config_loader;

  localparam int CW = 1602;
  localparam int WW = 32;
  localparam int NW = 51;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready, cfg_bit, cfg_enable, cfg_nreset;
  logic          core_nreset, busy, done, crc_error;

  config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW), .CLEAR_CYCLES(2)) dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .cfg_bit(cfg_bit), .cfg_enable(cfg_enable), .cfg_nreset(cfg_nreset),
    .core_nreset(core_nreset), .busy(busy), .done(done), .crc_error(crc_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model of the external config shift register plus activity monitors.
  int          cyc = 0;
  int          en_cnt = 0;
  logic [CW-1:0] sr = '0;
  logic        en_seen = 1'b0;
  int          first_en_cyc = 0;
  logic        first_en_bit = 1'b0;
  int          clr_run = 0;
  int          clr_last = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!cfg_nreset) begin
      sr      <= '0;
      en_seen <= 1'b0;
      clr_run <= clr_run + 1;
    end else begin
      if (clr_run != 0) begin
        clr_last <= clr_run;
        clr_run  <= 0;
      end
      if (cfg_enable) begin
        sr     <= {sr[CW-2:0], cfg_bit};
        en_cnt <= en_cnt + 1;
        if (!en_seen) begin
          en_seen      <= 1'b1;
          first_en_cyc <= cyc;
          first_en_bit <= cfg_bit;
        end
      end
    end
  end

  typedef struct {
    int pat;
    int gap;
    int crc_bad;
    int exp_en;
    int exp_lat;
    int exp_space;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [WW-1:0] gen_word(input int pat, input int i);
    logic [WW-1:0] w;
    case (pat)
      0:       w = (i == 0) ? 32'h0000_0001 : 32'h0000_0000;
      1:       w = (32'(i + 1) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
      default: w = 32'hFFFF_FFFF;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    c  = {c[14:0], 1'b0};
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [WW-1:0] d, input int gap, output int hs_at);
    int n;
    n = 0;
    while (!word_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!word_ready) begin
      chk("word_ready_wait", word_ready, 1);
      hs_at = -1;
      return;
    end
    repeat (gap) @(negedge clock);
    word_valid = 1'b1;
    word_data  = d;
    @(negedge clock);
    hs_at      = cyc;
    word_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [WW-1:0] w [NW];
    logic [CW-1:0] exp_sr;
    logic [15:0]   crc;
    logic          b;
    int c0, hs, prev_hs, bad_space, base_en, n, mism, extra, exp_core, exp_err;
    for (int i = 0; i < NW; i++) w[i] = gen_word(v.pat, i);
    exp_sr = '0;
    crc    = 16'hFFFF;
    for (int j = 0; j < CW; j++) begin
      b = w[j / WW][j % WW];
      exp_sr[CW-1-j] = b;
      crc = crc_step(crc, b);
    end
    base_en = en_cnt;
    start = 1'b1;
    c0    = cyc;
    @(negedge clock);
    start = 1'b0;
    chk("start_done_low", done, 0);
    chk("start_core_nreset_low", core_nreset, 0);
    chk("start_cfg_nreset_low", cfg_nreset, 0);
    chk("start_busy", busy, 1);
    chk("start_crc_error_clear", crc_error, 0);
    bad_space = 0;
    prev_hs   = -1;
    for (int i = 0; i < NW; i++) begin
      send_word(w[i], v.gap, hs);
      if (i > 0 && hs - prev_hs != v.exp_space) bad_space++;
      prev_hs = hs;
    end
`ifdef CONFIG_LOADER_CRC_EN
    send_word({16'h0000, crc ^ ((v.crc_bad != 0) ? 16'h0001 : 16'h0000)}, v.gap, hs);
    extra    = 1 + v.gap;
    exp_core = (v.crc_bad != 0) ? 0 : 1;
    exp_err  = (v.crc_bad != 0) ? 1 : 0;
`else
    extra    = 0;
    exp_core = 1;
    exp_err  = 0;
`endif
    n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("done_reached", done, 1);
    chk("done_latency", cyc - c0, v.exp_lat + extra);
    chk("enable_count", en_cnt - base_en, v.exp_en);
    chk("handshake_spacing_bad", bad_space, 0);
    chk("clear_cycles", clr_last, 2);
    mism = 0;
    for (int j = 0; j < CW; j++) if (sr[j] !== exp_sr[j]) mism++;
    chk("sr_mismatch_bits", mism, 0);
    chk("sr_pos_top", sr[CW-1], exp_sr[CW-1]);
    chk("done_core_nreset", core_nreset, exp_core);
    chk("done_crc_error", crc_error, exp_err);
    chk("done_busy", busy, 0);
    chk("done_word_ready", word_ready, 0);
    if (v.pat == 0) begin
      chk("first_enable_cycle", first_en_cyc - c0, 4 + v.gap);
      chk("first_enable_bit", first_en_bit, 1);
    end
    $display("load %0d pat=%0d gap=%0d latency=%0d enables=%0d core_nreset=%0d crc_error=%0d",
             idx, v.pat, v.gap, cyc - c0, en_cnt - base_en, core_nreset, crc_error);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_word_ready"}, word_ready, 0);
    chk({tag, "_cfg_bit"}, cfg_bit, 0);
    chk({tag, "_cfg_enable"}, cfg_enable, 0);
    chk({tag, "_cfg_nreset"}, cfg_nreset, 0);
    chk({tag, "_core_nreset"}, core_nreset, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_crc_error"}, crc_error, 0);
  endtask

  initial begin
    vec_t vecs [4];
    int   base, hs, n;

    // gap adds one LOAD wait per word: latency 1656 + 51*gap, spacing 33 + gap
    vecs[0] = '{pat: 0, gap: 0,  crc_bad: 0, exp_en: 1602, exp_lat: 1656, exp_space: 33};
    vecs[1] = '{pat: 1, gap: 0,  crc_bad: 0, exp_en: 1602, exp_lat: 1656, exp_space: 33};
    vecs[2] = '{pat: 1, gap: 10, crc_bad: 0, exp_en: 1602, exp_lat: 2166, exp_space: 43};
    vecs[3] = '{pat: 2, gap: 3,  crc_bad: 1, exp_en: 1602, exp_lat: 1809, exp_space: 36};

    // Reset values, then the first clock after release.
    repeat (3) @(negedge clock);
    chk_reset_values("reset");
    nreset = 1'b1;
    @(negedge clock);
    chk("release_cfg_nreset", cfg_nreset, 1);
    chk("release_busy", busy, 0);
    chk("release_core_nreset", core_nreset, 0);
    $display("reset released cfg_nreset=%0d busy=%0d", cfg_nreset, busy);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // abort in DONE returns to IDLE
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_done_done", done, 0);
    chk("abort_done_busy", busy, 0);
    chk("abort_done_core_nreset", core_nreset, 0);
    $display("abort in DONE: done=%0d busy=%0d", done, busy);

    // Abort during a load with a concurrently offered word.
    base  = en_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 16; i++) send_word(gen_word(1, i), 0, hs);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_ignored_cfg_nreset", cfg_nreset, 1);
    chk("start_ignored_cfg_enable", cfg_enable, 1);
    n = 0;
    while (!word_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("abort_reach_load", word_ready, 1);
    word_valid = 1'b1;
    word_data  = 32'hFFFF_FFFF;
    abort      = 1'b1;
    @(negedge clock);
    word_valid = 1'b0;
    abort      = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_word_ready", word_ready, 0);
    chk("abort_cfg_enable", cfg_enable, 0);
    chk("abort_core_nreset", core_nreset, 0);
    chk("abort_enables", en_cnt - base, 512);
    repeat (3) @(negedge clock);
    chk("abort_word_dropped", en_cnt - base, 512);
    chk("abort_stays_idle", busy, 0);
    $display("abort at bit %0d busy=%0d word_ready=%0d", en_cnt - base, busy, word_ready);
    run_vec(vecs[1], 4);

    // Asynchronous reset in the middle of a shift.
    base  = en_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 26; i++) send_word(gen_word(2, i), 0, hs);
    n = 0;
    while (en_cnt - base < 810 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("midload_cfg_enable", cfg_enable, 1);
    #2 nreset = 1'b0;
    #1 chk_reset_values("async_reset");
    $display("async reset at bit %0d", en_cnt - base);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    chk("rerelease_cfg_nreset", cfg_nreset, 1);
    chk("rerelease_busy", busy, 0);
    chk("rerelease_done", done, 0);
    run_vec(vecs[0], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Sequences the configuration shift register of the kFPGA core. It accepts the bitstream as parallel words over a valid/ready stream and clears the register first.
- It then serialises exactly CONFIG_WIDTH bits into it, one bit per clock, and holds the fabric in reset until loading completes.
- It sits between the host/bus bridge and the core top's config_in/config_enable/config_nreset pins. Its config clock is the same single clock.

Parameters:
- CONFIG_WIDTH, 1602: total configuration bits (shift-register length).
- WORD_WIDTH, 32: input word width.
- CLEAR_CYCLES, 2: cycles cfg_nreset is held low in CLEAR (must be >=1).

Ports:
- clock  input  1  single system/config clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- abort  input  1  cancels a load in progress; returns to IDLE.
- word_data  input  WORD_WIDTH  bitstream word, LSB shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts word this cycle.
- cfg_bit  output  1  serial data to shift register config_in.
- cfg_enable  output  1  shift enable to shift register.
- cfg_nreset  output  1  active-low clear to shift register.
- core_nreset  output  1  active-low fabric reset; low until configuration is complete.
- busy  output  1  high in CLEAR/LOAD/SHIFT (and CHECK when enabled).
- done  output  1  high in DONE.
- crc_error  output  1  sticky CRC mismatch flag (tied 0 without feature).

Behaviour:
- All outputs are registered.
- Reset values: word_ready=0, cfg_bit=0, cfg_enable=0, cfg_nreset=0, core_nreset=0, busy=0, done=0, crc_error=0.
- First clock after reset release: cfg_nreset=1, state IDLE.
- IDLE: outputs idle and core_nreset=0. start -> CLEAR.
- CLEAR: cfg_nreset=0 for exactly CLEAR_CYCLES cycles. The bit counter, word buffer and crc_error are cleared. -> LOAD.
- LOAD:
  - word_ready=1 and cfg_enable=0.
  - Transfer occurs on word_valid&&word_ready; the word is captured into the shift buffer -> SHIFT.
  - word_valid low: wait indefinitely; no timeout.
- SHIFT:
  - word_ready=0 and cfg_enable=1.
  - cfg_bit=buffer[0]; the buffer shifts right one bit per cycle and bit_count increments.
  - Leave when WORD_WIDTH bits of the word are sent, or bit_count reaches CONFIG_WIDTH, whichever is first.
  - Word exhausted and bit_count<CONFIG_WIDTH -> LOAD.
  - bit_count==CONFIG_WIDTH -> DONE (or CHECK with the feature). Unused upper bits of the final word are discarded.
- Throughput: WORD_WIDTH+1 cycles per full word (1 accept + WORD_WIDTH shifts).
- Default parameters: 51 words. The last word contributes bits [1:0] only (3 cycles). Total LOAD+SHIFT time is 50*33+3 = 1653 cycles.
- Bit order: the first bit shifted (word 0 bit 0) ends at shift-register position CONFIG_WIDTH-1 after CONFIG_WIDTH enables.
- cfg_enable is never high for more than CONFIG_WIDTH cycles per load.
- DONE:
  - done=1 and core_nreset=1 (fabric released on the cycle DONE is entered), unless crc_error=1, in which case core_nreset stays 0.
  - start -> CLEAR: done=0 and core_nreset=0 on the next cycle.
- abort (any busy state):
  - Next cycle: IDLE, cfg_enable=0, word_ready=0, core_nreset=0.
  - The partial configuration is left in the register and is cleared by the next CLEAR.
  - abort outranks start and outranks a simultaneous word handshake; that word is dropped and not counted.
- start while busy: ignored. abort in IDLE/DONE: DONE -> IDLE (done=0); IDLE unchanged.
- bit_count width: $clog2(CONFIG_WIDTH+1). Word bit index width: $clog2(WORD_WIDTH+1).
- nreset asserted mid-load: immediate return to reset values, asynchronously. The shift register is cleared via cfg_nreset=0.

Optional Feature:
- Macro: CONFIG_LOADER_CRC_EN.
- Enabled:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first register, one bit per cfg_enable cycle on cfg_bit) runs over all CONFIG_WIDTH bits.
  - After the last bit, state CHECK: word_ready=1 and the loader accepts one trailer word.
  - If trailer[15:0] != CRC, crc_error=1 (sticky until next CLEAR). -> DONE.
- Disabled: no CHECK state, no trailer word, and crc_error is tied 0.

Test Plan:
- Reset, then default params, start, stream 51 words (last word 0x00000003) with word_valid always 1 -> exactly 1602 cfg_enable cycles, handshakes spaced 33 cycles apart, done=1 and core_nreset=1 at cycle 1+2+1653 after start.
- word 0 = 0x00000001, rest 0 -> first cfg_bit pulse is on the first SHIFT cycle; a shift-register model shows position 1601=1 and all other positions 0.
- Insert 10-cycle word_valid gaps between words -> cfg_enable low during gaps, total enables still 1602, and no bit duplicated or lost against the reference model.
- abort asserted at bit 500 with a concurrent word_valid -> IDLE next cycle, word not accepted, core_nreset=0; restart clears the register (cfg_nreset low 2 cycles) and a reload completes correctly.
- nreset pulsed low at bit 800 -> all outputs at reset values immediately; start after release begins from CLEAR.
- CONFIG_LOADER_CRC_EN: correct trailer -> done=1, crc_error=0, core_nreset=1; trailer XOR 0x0001 -> crc_error=1, core_nreset stays 0; start then clears crc_error.
